// File: rtl/rc_osc_pkg.sv
// Shared types and defaults for the RC oscillator frequency meter.
package rc_osc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DONE
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    // clk cycles per osc period at 50 MHz clk / 500 kHz osc
    localparam int NOM_RATIO       = 100;

endpackage

// File: rtl/rc_osc_edge_sync.sv
// Synchronizer for the asynchronous oscillator output plus a
// one-cycle rising-edge pulse.
module rc_osc_edge_sync
    import rc_osc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/rc_osc_freq_meter.sv
// Measures clk cycles across N RC-oscillator periods and flags the
// result against a lo/hi window, with settle and no-edge watchdog.
module rc_osc_freq_meter
    import rc_osc_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SETTLE_EDGES = 4,
    parameter int TMO_W        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       n_periods,
    input  logic [CNT_W-1:0] lo_thresh,
    input  logic [CNT_W-1:0] hi_thresh,
    input  logic             osc_in,
    output logic             osc_ena,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] meas_count,
    output logic             too_fast,
    output logic             too_slow,
    output logic             timeout
);

    localparam int SW = $clog2(SETTLE_EDGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE_EDGES - 1);

    state_t             r_state;
    logic [7:0]         r_n;
    logic [7:0]         r_per;
    logic [CNT_W-1:0]   r_lo;
    logic [CNT_W-1:0]   r_hi;
    logic [CNT_W-1:0]   r_cyc;
    logic [SW-1:0]      r_settle;
    logic [TMO_W-1:0]   r_wdog;

    logic               w_rise;
    logic [CNT_W-1:0]   w_cyc_inc;
    logic [7:0]         w_per_inc;
    logic               w_wdog_max;

    rc_osc_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (osc_in),
        .o_rise  (w_rise)
    );

    assign w_cyc_inc  = (r_cyc == CNT_MAX) ? r_cyc : r_cyc + 1'b1;
    assign w_per_inc  = r_per + 8'd1;
    assign w_wdog_max = &r_wdog;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_per      <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_cyc      <= '0;
            r_settle   <= '0;
            r_wdog     <= '0;
            osc_ena    <= 1'b0;
            meas_valid <= 1'b0;
            meas_count <= '0;
            too_fast   <= 1'b0;
            too_slow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n      <= (n_periods == 8'd0) ? 8'd1 : n_periods;
                        r_lo     <= lo_thresh;
                        r_hi     <= hi_thresh;
                        r_cyc    <= '0;
                        r_per    <= '0;
                        r_settle <= '0;
                        r_wdog   <= '0;
                        osc_ena  <= 1'b1;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        osc_ena <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_rise) begin
                        r_wdog   <= '0;
                        r_settle <= r_settle + 1'b1;
                        if (r_settle == SET_LAST) begin
                            r_cyc   <= '0;
                            r_per   <= '0;
                            r_state <= MEASURE;
                        end
                    end else if (w_wdog_max) begin
                        meas_count <= r_cyc;
                        timeout    <= 1'b1;
                        too_slow   <= 1'b1;
                        too_fast   <= 1'b0;
                        meas_valid <= 1'b1;
                        osc_ena    <= 1'b0;
                        r_state    <= DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        osc_ena <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cyc <= w_cyc_inc;
                        if (w_rise) begin
                            r_wdog <= '0;
                            r_per  <= w_per_inc;
                            // final edge: the count includes this cycle
                            if (w_per_inc == r_n) begin
                                meas_count <= w_cyc_inc;
                                too_fast   <= (w_cyc_inc < r_lo);
                                too_slow   <= (w_cyc_inc > r_hi);
                                timeout    <= 1'b0;
                                meas_valid <= 1'b1;
                                osc_ena    <= 1'b0;
                                r_state    <= DONE;
                            end
                        end else if (w_wdog_max) begin
                            meas_count <= r_cyc;
                            timeout    <= 1'b1;
                            too_slow   <= 1'b1;
                            too_fast   <= 1'b0;
                            meas_valid <= 1'b1;
                            osc_ena    <= 1'b0;
                            r_state    <= DONE;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || meas_ack) begin
                        meas_valid <= 1'b0;
                        timeout    <= 1'b0;
                        too_fast   <= 1'b0;
                        too_slow   <= 1'b0;
                        osc_ena    <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
